// File: rtl/smac_stream_if.sv
// Beat and result channels of smac_stream: the DUT takes the slave modport and the feeder takes the master modport.
interface smac_stream_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   data_input;
    logic [DATA_W-1:0]   weight;
    logic [3:0]          select_precision;
    logic [CNT_W-1:0]    acc_len;
    logic                chain_en;
    logic [DATA_W-1:0]   chain_in;
    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_mac;
    logic [3:0]          res_precision;
    logic [DATA_W/8-1:0] overflow;

    modport master (
        output in_valid, data_input, weight, select_precision, acc_len, chain_en, chain_in, res_ready,
        input  in_ready, res_valid, res_mac, res_precision, overflow
    );
    modport slave (
        input  in_valid, data_input, weight, select_precision, acc_len, chain_en, chain_in, res_ready,
        output in_ready, res_valid, res_mac, res_precision, overflow
    );
endinterface

// File: rtl/smac_stream.sv
// Streaming lane-wise SIMD multiply-accumulate with per-group precision, length and chain seed.
// Define SMAC_SATURATE_EN to clamp lanes at emission and drive the overflow flags; otherwise lanes wrap.
//
// state | meaning
// IDLE  | waiting for the first beat of a group
// ACC   | accepting the remaining beats of the group
// WAIT  | pipeline draining after the last beat
// HOLD  | result presented until res_ready
module smac_stream #(
    parameter int    DATA_W     = 64,
    parameter int    CNT_W      = 8,
    parameter string USE_FABRIC = "NO"
) (
    input logic          clk,
    input logic          aresetn,
    input logic          ce,
    input logic          sclr,
    smac_stream_if.slave io
);
    // Encoding of the precision codes in precision_def.vh
    localparam logic [3:0] INT8 = 4'd0, INT16 = 4'd1, INT32 = 4'd2, INT64 = 4'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ACC, WAIT, HOLD} state_t;

    state_t                   state, state_nx;
    logic [CNT_W-1:0]         cnt, grp_len, eff_len;
    logic [3:0]               grp_prec;
    logic                     accept, first_beat, last_beat;
    logic                     p1_valid, p1_last, p2_last;
    logic [3:0][DATA_W-1:0]   w_res;
    logic [3:0][DATA_W/8-1:0] w_ovf;
    logic [DATA_W-1:0]        sel_res;
    logic [DATA_W/8-1:0]      sel_ovf;

    if (DATA_W != 64 && DATA_W != 128 && DATA_W != 256) begin : g_bad_width
        $error("smac_stream: DATA_W must be 64, 128 or 256");
    end

    assign io.in_ready = ce & aresetn & (state == IDLE || state == ACC);
    assign accept      = io.in_valid & io.in_ready;
    assign first_beat  = accept & (state == IDLE);
    assign eff_len     = (io.acc_len == '0) ? CNT_ONE : io.acc_len;
    assign last_beat   = accept & ((state == IDLE) ? (eff_len == CNT_ONE)
                                                   : (cnt == grp_len - CNT_ONE));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = last_beat ? WAIT : ACC;
            ACC:     if (last_beat) state_nx = WAIT;
            WAIT:    if (p2_last) state_nx = HOLD;
            HOLD:    if (io.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE; cnt <= '0; grp_len <= '0; grp_prec <= '0;
            p1_valid <= 1'b0; p1_last <= 1'b0; p2_last <= 1'b0;
            io.res_valid <= 1'b0; io.res_mac <= '0; io.res_precision <= '0; io.overflow <= '0;
        end else if (sclr) begin
            state <= IDLE; cnt <= '0; grp_len <= '0; grp_prec <= '0;
            p1_valid <= 1'b0; p1_last <= 1'b0; p2_last <= 1'b0;
            io.res_valid <= 1'b0; io.res_mac <= '0; io.res_precision <= '0; io.overflow <= '0;
        end else if (ce) begin
            state    <= state_nx;
            p1_valid <= accept;
            p1_last  <= last_beat;
            p2_last  <= p1_last;
            if (first_beat) begin
                cnt      <= CNT_ONE;
                grp_len  <= eff_len;
                grp_prec <= io.select_precision;
            end else if (accept) begin
                cnt <= cnt + CNT_ONE;
            end
            if (state == WAIT && p2_last) begin
                io.res_valid     <= 1'b1;
                io.res_mac       <= sel_res;
                io.res_precision <= grp_prec;
                io.overflow      <= sel_ovf;
            end else if (state == HOLD && io.res_ready) begin
                io.res_valid <= 1'b0;
            end
        end
    end

    // Every width keeps its own lane set; the group precision picks one at emission.
    for (genvar k = 0; k < 4; k++) begin : g_w
        localparam int W  = 8 << k;
        localparam int N  = DATA_W / W;
        localparam int AW = 2 * W + CNT_W;
        for (genvar j = 0; j < N; j++) begin : g_lane
            logic [W-1:0]          a, b, c;
            logic signed [2*W-1:0] ax, bx, mul, prod;
            logic signed [AW-1:0]  acc;

            assign a  = io.data_input[j*W +: W];
            assign b  = io.weight[j*W +: W];
            assign c  = io.chain_in[j*W +: W];
            assign ax = {{W{a[W-1]}}, a};
            assign bx = {{W{b[W-1]}}, b};

            if (USE_FABRIC == "YES") begin : g_fab
                (* use_dsp = "no" *) logic signed [2*W-1:0] m;
                assign m   = ax * bx;
                assign mul = m;
            end else begin : g_dsp
                (* use_dsp = "yes" *) logic signed [2*W-1:0] m;
                assign m   = ax * bx;
                assign mul = m;
            end

            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    prod <= '0; acc <= '0;
                end else if (sclr) begin
                    prod <= '0; acc <= '0;
                end else if (ce) begin
                    if (accept) prod <= mul;
                    if (first_beat) acc <= io.chain_en ? {{(AW-W){c[W-1]}}, c} : '0;
                    else if (p1_valid) acc <= acc + {{CNT_W{prod[2*W-1]}}, prod};
                end
            end

`ifdef SMAC_SATURATE_EN
            logic sat_hi, sat_lo;
            assign sat_hi = ~acc[AW-1] & (|acc[AW-2:W-1]);
            assign sat_lo = acc[AW-1] & ~(&acc[AW-2:W-1]);
            assign w_res[k][j*W +: W] = sat_hi ? {1'b0, {(W-1){1'b1}}} :
                                        sat_lo ? {1'b1, {(W-1){1'b0}}} : acc[W-1:0];
            assign w_ovf[k][j*(W/8) +: W/8] = {(W/8){sat_hi | sat_lo}};
`else
            assign w_res[k][j*W +: W] = acc[W-1:0];
            assign w_ovf[k][j*(W/8) +: W/8] = '0;
`endif
        end
    end

    // Unsupported codes (fp included) emit zero.
    always_comb begin
        sel_res = '0;
        sel_ovf = '0;
        case (grp_prec)
            INT8:    begin sel_res = w_res[0]; sel_ovf = w_ovf[0]; end
            INT16:   begin sel_res = w_res[1]; sel_ovf = w_ovf[1]; end
            INT32:   begin sel_res = w_res[2]; sel_ovf = w_ovf[2]; end
            INT64:   begin sel_res = w_res[3]; sel_ovf = w_ovf[3]; end
            default: ;
        endcase
    end
endmodule
